reg_bus_master: RTL and testbench

- Bus initiator that drives the peripheral register bus (addr[5:2], wben, r_wn, wdata -> rdata) consumed by the chip register block.
- Converts core load/store requests (valid/ready, byte address, size, signed) into single register-bus transactions.
- Generates byte enables and lane-replicated write data, waits the configured read latency, and returns aligned, extended read data.
- Sits between the RISC-V core data port and the register block.

---
 rtl/reg_bus_master_if.sv | 34 +++
 rtl/reg_bus_master.sv | 195 +++++++++++++++++++
 tb/tb_reg_bus_master.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_master_if.sv
// Signal bundle between the core-side request/response port, the register-bus
// master and the register-block responder.
interface reg_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  bus_addr;
    logic [3:0]  bus_wben;
    logic        bus_r_wn;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        input  req_valid, req_addr, req_we, req_size, req_signed, req_wdata,
        input  rsp_ready, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output bus_addr, bus_wben, bus_r_wn, bus_wdata
    );

    modport slave (
        output req_valid, req_addr, req_we, req_size, req_signed, req_wdata,
        output rsp_ready, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  bus_addr, bus_wben, bus_r_wn, bus_wdata
    );
endinterface

// File: rtl/reg_bus_master.sv
// Turns one core load/store into a single register-bus transaction and
// returns lane-aligned, extended read data (or an error) on the response port.
module reg_bus_master #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    reg_bus_master_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [1:0] LAT_LAST = RD_LAT[1:0];

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [3:0]  bus_addr_q, bus_addr_d;
    logic [3:0]  bus_wben_q, bus_wben_d;
    logic        bus_r_wn_q, bus_r_wn_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        in_win_s;
    logic        dec_err_s;

    function automatic logic [3:0] lane_wben(input logic [1:0] off, input logic [1:0] size);
        case (size)
            2'd0:    lane_wben = 4'b0001 << off;
            2'd1:    lane_wben = 4'b0011 << off;
            default: lane_wben = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [31:0] data, input logic [1:0] size);
        case (size)
            2'd0:    lane_wdata = {4{data[7:0]}};
            2'd1:    lane_wdata = {2{data[15:0]}};
            default: lane_wdata = data;
        endcase
    endfunction

    // The responder always returns the full word; pick the addressed lane and extend.
    function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'd0:    load_align = {{24{sgn & sh[7]}}, sh[7:0]};
            2'd1:    load_align = {{16{sgn & sh[15]}}, sh[15:0]};
            default: load_align = sh;
        endcase
    endfunction

    assign in_win_s  = (bus.req_addr[31:6] == BASE_ADDR[31:6]);
    assign dec_err_s = !in_win_s
                    || (bus.req_size == 2'd3)
                    || ((bus.req_size == 2'd1) && bus.req_addr[0])
                    || ((bus.req_size == 2'd2) && (bus.req_addr[1:0] != 2'd0));

    // Next-state and next-output logic; write strobes fall back to idle by default.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        bus_addr_d  = bus_addr_q;
        bus_wben_d  = 4'b0000;
        bus_r_wn_d  = 1'b1;
        bus_wdata_d = 32'd0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_ready_d = 1'b0;
                    off_d       = bus.req_addr[1:0];
                    size_d      = bus.req_size;
                    sgn_d       = bus.req_signed;
                    if (dec_err_s) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else if (bus.req_we) begin
                        state_d     = WRITE;
                        bus_addr_d  = bus.req_addr[5:2];
                        bus_r_wn_d  = 1'b0;
                        bus_wben_d  = lane_wben(bus.req_addr[1:0], bus.req_size);
                        bus_wdata_d = lane_wdata(bus.req_wdata, bus.req_size);
                    end else begin
                        state_d    = READ;
                        bus_addr_d = bus.req_addr[5:2];
                        cnt_d      = 2'd0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'd0;
            end
            READ: begin
                if (cnt_q == LAT_LAST) begin
                    state_d     = RESP;
                    cnt_d       = 2'd0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_align(bus.bus_rdata, off_q, size_q, sgn_q);
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = 32'd0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            sgn_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            bus_addr_q  <= 4'd0;
            bus_wben_q  <= 4'b0000;
            bus_r_wn_q  <= 1'b1;
            bus_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            bus_addr_q  <= bus_addr_d;
            bus_wben_q  <= bus_wben_d;
            bus_r_wn_q  <= bus_r_wn_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wben  = bus_wben_q;
    assign bus.bus_r_wn  = bus_r_wn_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_reg_bus_master.sv
// Scoreboard bench for reg_bus_master: a small register-block responder, expected
// responses and bus writes queued at request time and matched when they appear.
module tb_reg_bus_master;

    localparam int          RD_LAT = 1;
    localparam logic [31:0] BASE   = 32'h4000_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } rsp_t;

    typedef struct {
        logic [3:0]  addr;
        logic [3:0]  wben;
        logic [31:0] wdata;
    } wr_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic mon_en = 1'b0;
    logic rsp_pending = 1'b0;
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    logic [31:0] mem    [16];
    logic [31:0] shadow [16];
    logic [31:0] rd_pipe[3];

    reg_bus_master_if rb();

    reg_bus_master #(.BASE_ADDR(BASE), .RD_LAT(RD_LAT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [3:0] i);
        case (i)
            4'd0:    return 32'h4852_4A44;
            4'd6:    return 32'h8001_1234;
            default: return {4'hD, i, 24'h00_C0DE};
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] sz, input logic sg);
        logic [31:0] s;
        s = w >> (8 * off);
        if (sz == 2'd0) return sg ? {{24{s[7]}}, s[7:0]} : {24'd0, s[7:0]};
        if (sz == 2'd1) return sg ? {{16{s[15]}}, s[15:0]} : {16'd0, s[15:0]};
        return s;
    endfunction

    // Register-block responder: byte-enabled writes, RD_LAT-deep registered read path.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(4'(i));
            for (int i = 0; i < 3; i++) rd_pipe[i] <= 32'd0;
        end else begin
            if (rb.bus_r_wn === 1'b0) mem[rb.bus_addr] <= merge(mem[rb.bus_addr], rb.bus_wben, rb.bus_wdata);
            rd_pipe[0] <= mem[rb.bus_addr];
            rd_pipe[1] <= rd_pipe[0];
            rd_pipe[2] <= rd_pipe[1];
        end
    end
    assign rb.bus_rdata = rd_pipe[RD_LAT-1];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Bus and response monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rb.bus_r_wn === 1'b0) begin
                check_eq("write_expected", 64'(wr_q.size() != 0), 64'd1);
                if (wr_q.size() != 0) begin
                    check_eq("wr_addr",  64'(rb.bus_addr),  64'(wr_q[0].addr));
                    check_eq("wr_wben",  64'(rb.bus_wben),  64'(wr_q[0].wben));
                    check_eq("wr_wdata", 64'(rb.bus_wdata), 64'(wr_q[0].wdata));
                    void'(wr_q.pop_front());
                end
            end else begin
                check_eq("bus_idle_lanes", 64'({rb.bus_r_wn, rb.bus_wben, rb.bus_wdata}), 64'({1'b1, 36'd0}));
            end
            if (rb.rsp_valid === 1'b1) begin
                check_eq("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
                if (rsp_q.size() != 0) begin
                    if (!rsp_pending) check_eq("rsp_latency", 64'(cyc), 64'(rsp_q[0].due));
                    check_eq("rsp_rdata", 64'(rb.rsp_rdata), 64'(rsp_q[0].rdata));
                    check_eq("rsp_err",   64'(rb.rsp_err),   64'(rsp_q[0].err));
                    check_eq("req_ready_in_resp", 64'(rb.req_ready), 64'd0);
                    if (rb.rsp_ready === 1'b1) void'(rsp_q.pop_front());
                end
            end
            rsp_pending <= (rb.rsp_valid === 1'b1) && (rb.rsp_ready !== 1'b1);
        end
    end

    task automatic do_req(input logic [31:0] addr, input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] wd, input logic e, input logic [31:0] exp_rdata,
                          input logic [3:0] exp_wben, input logic [31:0] exp_wdata, output int t_acc);
        rsp_t r;
        wr_t  w;
        int   g;
        rb.req_valid  = 1'b1;
        rb.req_addr   = addr;
        rb.req_we     = we;
        rb.req_size   = sz;
        rb.req_signed = sg;
        rb.req_wdata  = wd;
        g = 0;
        while (rb.req_ready !== 1'b1 && g < 64) begin
            @(posedge clk); #1;
            g++;
        end
        check_eq("req_accept_timeout", 64'(g < 64), 64'd1);
        t_acc   = cyc;
        r.rdata = exp_rdata;
        r.err   = e;
        r.due   = t_acc + (e ? 1 : (we ? 2 : 2 + RD_LAT));
        rsp_q.push_back(r);
        if (we && !e) begin
            w.addr  = addr[5:2];
            w.wben  = exp_wben;
            w.wdata = exp_wdata;
            wr_q.push_back(w);
            shadow[addr[5:2]] = merge(shadow[addr[5:2]], exp_wben, exp_wdata);
        end
        @(posedge clk); #1;
        rb.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((rsp_q.size() != 0 || rb.req_ready !== 1'b1) && g < 64) begin
            @(posedge clk); #1;
            g++;
        end
        check_eq("idle_timeout", 64'(g < 64), 64'd1);
    endtask

    task automatic pulse_reset();
        rsp_q.delete();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = init_word(4'(i));
    endtask

    initial begin
        logic [3:0]  idx;
        logic [1:0]  sz, off;
        logic        we, sg, e;
        logic [31:0] wd, a, er;
        int          t, h, g;

        rb.req_valid  = 1'b0;
        rb.req_addr   = 32'd0;
        rb.req_we     = 1'b0;
        rb.req_size   = 2'd0;
        rb.req_signed = 1'b0;
        rb.req_wdata  = 32'd0;
        rb.rsp_ready  = 1'b1;
        for (int i = 0; i < 16; i++) shadow[i] = init_word(4'(i));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("reset_ctrl", 64'({rb.req_ready, rb.rsp_valid, rb.rsp_err, rb.bus_r_wn, rb.bus_wben, rb.bus_addr}),
                 64'({1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0}));
        check_eq("reset_data", 64'({rb.rsp_rdata, rb.bus_wdata}), 64'd0);
        mon_en = 1'b1;

        // Directed loads, stores and their read-back.
        do_req(32'h4000_0000, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0, 32'h4852_4A44, 4'h0, 32'd0, t); wait_idle();
        do_req(32'h4000_001A, 1'b0, 2'd1, 1'b1, 32'd0, 1'b0, 32'hFFFF_8001, 4'h0, 32'd0, t); wait_idle();
        do_req(32'h4000_001A, 1'b0, 2'd1, 1'b0, 32'd0, 1'b0, 32'h0000_8001, 4'h0, 32'd0, t); wait_idle();
        do_req(32'h4000_0019, 1'b1, 2'd0, 1'b0, 32'h0000_00A5, 1'b0, 32'd0, 4'b0010, 32'hA5A5_A5A5, t); wait_idle();
        do_req(32'h4000_0019, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0, 32'h0000_00A5, 4'h0, 32'd0, t); wait_idle();
        do_req(32'h4000_0019, 1'b0, 2'd0, 1'b1, 32'd0, 1'b0, 32'hFFFF_FFA5, 4'h0, 32'd0, t); wait_idle();
        do_req(32'h4000_0012, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF, 1'b0, 32'd0, 4'b1100, 32'hBEEF_BEEF, t); wait_idle();
        do_req(32'h4000_0010, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0, 32'hBEEF_C0DE, 4'h0, 32'd0, t); wait_idle();
        do_req(32'h4000_003C, 1'b1, 2'd2, 1'b0, 32'h1234_5678, 1'b0, 32'd0, 4'b1111, 32'h1234_5678, t); wait_idle();
        do_req(32'h4000_003F, 1'b0, 2'd0, 1'b1, 32'd0, 1'b0, 32'h0000_0012, 4'h0, 32'd0, t); wait_idle();

        // Error cases: no bus activity, response one cycle after acceptance.
        do_req(32'h4000_0006, 1'b0, 2'd2, 1'b0, 32'd0, 1'b1, 32'd0, 4'h0, 32'd0, t); wait_idle();
        do_req(32'h4000_0003, 1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'd0, 4'h0, 32'd0, t); wait_idle();
        do_req(32'h4000_0004, 1'b0, 2'd3, 1'b0, 32'd0, 1'b1, 32'd0, 4'h0, 32'd0, t); wait_idle();
        do_req(32'h5000_0000, 1'b0, 2'd2, 1'b0, 32'd0, 1'b1, 32'd0, 4'h0, 32'd0, t); wait_idle();
        do_req(32'h5000_0000, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b1, 32'd0, 4'h0, 32'd0, t); wait_idle();

        // Backpressure: response held four cycles while a new request waits.
        rb.rsp_ready = 1'b0;
        do_req(32'h4000_0000, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0, 32'h4852_4A44, 4'h0, 32'd0, t);
        rb.req_valid = 1'b1;
        rb.req_addr  = 32'h4000_0008;
        rb.req_we    = 1'b1;
        rb.req_size  = 2'd0;
        rb.req_wdata = 32'h0000_005A;
        g = 0;
        while (rb.rsp_valid !== 1'b1 && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check_eq("bp_rsp_timeout", 64'(g < 20), 64'd1);
        repeat (4) begin
            check_eq("bp_req_ready", 64'(rb.req_ready), 64'd0);
            @(posedge clk); #1;
        end
        rb.rsp_ready = 1'b1;
        h = cyc;
        do_req(32'h4000_0008, 1'b1, 2'd0, 1'b0, 32'h0000_005A, 1'b0, 32'd0, 4'b0001, 32'h5A5A_5A5A, t);
        check_eq("bp_accept_cycle", 64'(t), 64'(h + 1));
        wait_idle();

        // Reset in the middle of a store and of a load.
        do_req(32'h4000_0020, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'd0, 4'b1111, 32'hDEAD_BEEF, t);
        pulse_reset();
        check_eq("rst_write_ctrl", 64'({rb.bus_r_wn, rb.bus_wben, rb.rsp_valid, rb.req_ready}), 64'({1'b1, 4'h0, 1'b0, 1'b1}));
        repeat (4) @(posedge clk);
        #1;
        do_req(32'h4000_0024, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0, 32'd0, 4'h0, 32'd0, t);
        pulse_reset();
        check_eq("rst_read_ctrl", 64'({rb.bus_r_wn, rb.bus_wben, rb.rsp_valid, rb.req_ready}), 64'({1'b1, 4'h0, 1'b0, 1'b1}));
        repeat (4) @(posedge clk);
        #1;
        do_req(32'h4000_003C, 1'b0, 2'd2, 1'b0, 32'd0, 1'b0, 32'hDF00_C0DE, 4'h0, 32'd0, t); wait_idle();

        // Random traffic against the bench's shadow register file.
        for (int i = 0; i < 40; i++) begin
            idx = 4'($urandom_range(15, 0));
            sz  = 2'($urandom_range(2, 0));
            we  = 1'($urandom_range(1, 0));
            sg  = 1'($urandom_range(1, 0));
            wd  = $urandom;
            off = (sz == 2'd0) ? 2'($urandom_range(3, 0)) : (sz == 2'd1) ? {1'($urandom_range(1, 0)), 1'b0} : 2'd0;
            if (i % 8 == 7) off = 2'd1;
            a  = BASE | {26'd0, idx, off};
            e  = ((sz == 2'd1) && off[0]) || ((sz == 2'd2) && (off != 2'd0));
            er = (we || e) ? 32'd0 : model_load(shadow[idx], off, sz, sg);
            do_req(a, we, sz, sg, wd, e, er,
                   (sz == 2'd0) ? 4'(4'b0001 << off) : (sz == 2'd1) ? 4'(4'b0011 << off) : 4'b1111,
                   (sz == 2'd0) ? {4{wd[7:0]}} : (sz == 2'd1) ? {2{wd[15:0]}} : wd, t);
            wait_idle();
        end

        repeat (5) @(posedge clk);
        #1;
        check_eq("rsp_drain", 64'(rsp_q.size()), 64'd0);
        check_eq("wr_drain",  64'(wr_q.size()),  64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: observed cycle %0d required completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
